// File: rtl/s298_bist_ctrl_if.sv
// Bus between the test-access side and the s298 BIST sequencer: test control,
// CUT stimulus/response pins, status and the compacted signature.
interface s298_bist_ctrl_if;
  // Handshake: START is a level sampled on a rising edge while idle (IDLE or DONE).
  // It is ignored while BUSY. DONE rises once per completed test and then holds,
  // with PASS/SIGNATURE, until the next START, ABORT or reset. ABORT overrides
  // everything and returns the sequencer to IDLE on the next edge.
  logic        START;
  logic        ABORT;
  logic [15:0] EXP_SIG;
  logic [5:0]  CUT_OUT;
  logic        CUT_G0;
  logic        CUT_G1;
  logic        CUT_G2;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic [15:0] SIGNATURE;
  logic [2:0]  STATE_DBG;

  modport master (
    output START, ABORT, EXP_SIG, CUT_OUT,
    input  CUT_G0, CUT_G1, CUT_G2, BUSY, DONE, PASS, SIGNATURE, STATE_DBG
  );

  modport slave (
    input  START, ABORT, EXP_SIG, CUT_OUT,
    output CUT_G0, CUT_G1, CUT_G2, BUSY, DONE, PASS, SIGNATURE, STATE_DBG
  );
endinterface

// File: rtl/s298_bist_ctrl.sv
// BIST sequencer for the s298 core: clears the CUT, drives LFSR patterns on G1/G2,
// compacts the CUT outputs into a MISR and compares the final signature.
module s298_bist_ctrl #(
  parameter logic [15:0] LFSR_POLY    = 16'hB400,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [15:0] MISR_POLY    = 16'h1021,
  parameter int          INIT_CYCLES  = 4,
  parameter int          PATTERNS     = 1024,
  parameter int          DRAIN_CYCLES = 2
) (
  input logic              CLOCK,
  input logic              RESET_N,
  input logic              VSS,
  input logic              VDD,
  s298_bist_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int MAX_IR  = (INIT_CYCLES > PATTERNS) ? INIT_CYCLES : PATTERNS;
  localparam int CNT_MAX = (MAX_IR > DRAIN_CYCLES) ? MAX_IR : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counters load length-1 and the state is left when they reach zero.
  localparam logic [CNT_W-1:0] INIT_LD  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LD   = CNT_W'(PATTERNS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]      SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  // Supply pins exist only so the port list matches the netlist.
  logic unused_supply;
  assign unused_supply = VSS ^ VDD;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_d;
  logic [15:0]      sig_q;
  logic [15:0]      sig_d;
  logic             g0_q;
  logic             g1_q;
  logic             g2_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
    sig_d  = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000)
           ^ {10'b0, bus.CUT_OUT};
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      sig_q   <= '0;
      g0_q    <= 1'b1;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (bus.ABORT) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      sig_q   <= '0;
      g0_q    <= 1'b1;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.START) begin
            state_q <= S_INIT;
            cnt_q   <= INIT_LD;
            lfsr_q  <= SEED;
            sig_q   <= '0;
            g0_q    <= 1'b1;
            g1_q    <= 1'b0;
            g2_q    <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end

        S_INIT: begin
          if (cnt_q == '0) begin
            state_q <= S_RUN;
            cnt_q   <= RUN_LD;
            g0_q    <= 1'b0;
            g1_q    <= lfsr_q[0];
            g2_q    <= lfsr_q[1];
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_RUN: begin
          lfsr_q <= lfsr_d;
          sig_q  <= sig_d;
          if (cnt_q == '0) begin
            g1_q <= 1'b0;
            g2_q <= 1'b0;
            if (DRAIN_CYCLES > 0) begin
              state_q <= S_DRAIN;
              cnt_q   <= DRAIN_LD;
            end else begin
              // No drain phase: this RUN edge is the last capture.
              state_q <= S_DONE;
              cnt_q   <= '0;
              g0_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (sig_d == bus.EXP_SIG);
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
            g1_q  <= lfsr_d[0];
            g2_q  <= lfsr_d[1];
          end
        end

        S_DRAIN: begin
          sig_q <= sig_d;
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            g0_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (sig_d == bus.EXP_SIG);
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          g0_q    <= 1'b1;
          g1_q    <= 1'b0;
          g2_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CUT_G0    = g0_q;
  assign bus.CUT_G1    = g1_q;
  assign bus.CUT_G2    = g2_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.SIGNATURE = sig_q;
  assign bus.STATE_DBG = state_q;

endmodule
